// File: rtl/hd_controller.sv
// Sector mover between a hard-disk word port and a memory word port.
// One command copies SECTOR_WORDS words HD->mem (OpHD=1) or mem->HD (OpHD=2), one per cycle.
module hd_controller #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SECTOR_WORDS = 32,
  parameter int unsigned SECT_W       = 8,
  parameter int unsigned MEM_AW       = 10
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [1:0]                                OpHD,
  input  logic [SECT_W-1:0]                         setor,
  input  logic [MEM_AW-1:0]                         mem_base,
  output logic [SECT_W+$clog2(SECTOR_WORDS)-1:0]    hd_addr,
  input  logic [DATA_W-1:0]                         hd_rd_data,
  output logic                                      hd_wr_en,
  output logic [DATA_W-1:0]                         hd_wr_data,
  output logic [MEM_AW-1:0]                         mem_addr,
  input  logic [DATA_W-1:0]                         mem_rd_data,
  output logic                                      mem_wr_en,
  output logic [DATA_W-1:0]                         mem_wr_data,
  output logic                                      ocupado,
  output logic                                      pronto
);

  localparam int unsigned IdxW = $clog2(SECTOR_WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SECTOR_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StDone} state_e;

  state_e              state;
  logic                op_wr;    // 1: mem->HD, 0: HD->mem
  logic [SECT_W-1:0]   setor_l;
  logic [MEM_AW-1:0]   base_l;
  logic [IdxW-1:0]     idx;      // index of the address issued this cycle
  logic [IdxW-1:0]     widx;     // index whose data arrives this cycle
  logic                wr_v;
  logic                wr_act;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= StIdle;
      op_wr   <= 1'b0;
      setor_l <= '0;
      base_l  <= '0;
      idx     <= '0;
      widx    <= '0;
      wr_v    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          wr_v <= 1'b0;
          if (OpHD == 2'd1 || OpHD == 2'd2) begin
            op_wr   <= (OpHD == 2'd2);
            setor_l <= setor;
            base_l  <= mem_base;
            idx     <= '0;
            state   <= StXfer;
          end
        end
        StXfer: begin
          widx <= idx;
          wr_v <= 1'b1;
          if (idx == LastIdx) state <= StDrain;
          else                idx   <= idx + IdxW'(1);
        end
        StDrain: begin
          wr_v  <= 1'b0;
          state <= StDone;
        end
        StDone: begin
          if (OpHD == 2'd0) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign wr_act  = ((state == StXfer) && wr_v) || (state == StDrain);
  assign ocupado = (state == StXfer) || (state == StDrain);
  assign pronto  = (state == StDone);

  // Read-side address and write-side address go to different ports, so they never collide.
  always_comb begin
    hd_addr     = '0;
    mem_addr    = '0;
    hd_wr_en    = 1'b0;
    mem_wr_en   = 1'b0;
    hd_wr_data  = '0;
    mem_wr_data = '0;
    if (state == StXfer) begin
      if (op_wr) mem_addr = base_l + MEM_AW'(idx);
      else       hd_addr  = {setor_l, idx};
    end
    if (wr_act) begin
      if (op_wr) begin
        hd_wr_en   = 1'b1;
        hd_addr    = {setor_l, widx};
        hd_wr_data = mem_rd_data;
      end else begin
        mem_wr_en   = 1'b1;
        mem_addr    = base_l + MEM_AW'(widx);
        mem_wr_data = hd_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_hd_controller.sv
// Bench for hd_controller with N=4: HD and memory models answer with one-cycle latency,
// and every observed write is compared against a word-by-word copy model.
module tb_hd_controller;
  localparam int unsigned N      = 4;
  localparam int unsigned DW     = 32;
  localparam int unsigned SW     = 8;
  localparam int unsigned AW     = 10;
  localparam int unsigned HAW    = SW + 2;
  localparam int unsigned MSIZE  = 1 << AW;
  localparam int unsigned HSIZE  = 1 << HAW;

  logic           clock = 1'b0;
  logic           reset;
  logic [1:0]     OpHD;
  logic [SW-1:0]  setor;
  logic [AW-1:0]  mem_base;
  logic [HAW-1:0] hd_addr;
  logic [DW-1:0]  hd_rd_data;
  logic           hd_wr_en;
  logic [DW-1:0]  hd_wr_data;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rd_data;
  logic           mem_wr_en;
  logic [DW-1:0]  mem_wr_data;
  logic           ocupado;
  logic           pronto;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] hd_store  [HSIZE];
  logic [DW-1:0] mem_store [MSIZE];

  // Write logs, filled only by the monitor.
  logic [HAW-1:0] hd_wa  [4096];
  logic [DW-1:0]  hd_wd  [4096];
  logic [AW-1:0]  mem_wa [4096];
  logic [DW-1:0]  mem_wd [4096];
  int hd_wcnt = 0;
  int mem_wcnt = 0;
  int both_err = 0;
  int idle_err = 0;

  hd_controller #(
    .DATA_W(DW), .SECTOR_WORDS(N), .SECT_W(SW), .MEM_AW(AW)
  ) dut (
    .clock(clock), .reset(reset), .OpHD(OpHD), .setor(setor), .mem_base(mem_base),
    .hd_addr(hd_addr), .hd_rd_data(hd_rd_data), .hd_wr_en(hd_wr_en),
    .hd_wr_data(hd_wr_data), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .ocupado(ocupado), .pronto(pronto)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    hd_rd_data  <= hd_store[hd_addr];
    mem_rd_data <= mem_store[mem_addr];
  end

  always @(negedge clock) begin
    if (hd_wr_en && mem_wr_en) both_err++;
    if (!ocupado && (hd_wr_en || mem_wr_en)) idle_err++;
    if (hd_wr_en && hd_wcnt < 4096) begin
      hd_wa[hd_wcnt] = hd_addr;
      hd_wd[hd_wcnt] = hd_wr_data;
      hd_wcnt++;
    end
    if (mem_wr_en && mem_wcnt < 4096) begin
      mem_wa[mem_wcnt] = mem_addr;
      mem_wd[mem_wcnt] = mem_wr_data;
      mem_wcnt++;
    end
  end

  // Issue one command and check latency, the write stream and the return to idle.
  task automatic run_op(input logic [1:0] op, input logic [SW-1:0] sect,
                        input logic [AW-1:0] base, input bit hold, input string name);
    logic [HAW-1:0] ea_h [N];
    logic [AW-1:0]  ea_m [N];
    logic [DW-1:0]  ed   [N];
    int h0, m0, edges, nw, nother;
    bit busy_ok, ok;
    for (int k = 0; k < N; k++) begin
      ea_h[k] = {sect, 2'(k)};
      ea_m[k] = base + AW'(k);
      ed[k]   = (op == 2'd1) ? hd_store[ea_h[k]] : mem_store[ea_m[k]];
    end
    h0 = hd_wcnt;
    m0 = mem_wcnt;
    @(negedge clock);
    OpHD = op; setor = sect; mem_base = base;
    @(posedge clock); #1;
    OpHD     = hold ? 2'd1 : 2'($urandom_range(0, 3));
    setor    = SW'($urandom);
    mem_base = AW'($urandom);
    busy_ok  = ocupado;
    edges    = 0;
    while (edges < 20) begin
      @(posedge clock); #1;
      edges++;
      if (pronto) break;
      if (!ocupado) busy_ok = 1'b0;
    end
    checks++;
    if (edges !== N + 1) $display("FAIL %s latency: pronto after %0d edges, want %0d", name, edges, N + 1);
    else passed++;
    checks++;
    if (!busy_ok) $display("FAIL %s ocupado: dropped during transfer, want 1", name);
    else passed++;
    if (hold) begin
      repeat (3) begin
        @(posedge clock); #1;
        checks++;
        if (pronto !== 1'b1 || ocupado !== 1'b0)
          $display("FAIL %s done_hold: pronto=%b ocupado=%b, want 1/0", name, pronto, ocupado);
        else passed++;
      end
    end
    @(negedge clock);
    OpHD = 2'd0;
    @(posedge clock); #1;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b0)
      $display("FAIL %s to_idle: pronto=%b ocupado=%b, want 0/0", name, pronto, ocupado);
    else passed++;
    nw     = (op == 2'd1) ? mem_wcnt - m0 : hd_wcnt - h0;
    nother = (op == 2'd1) ? hd_wcnt - h0 : mem_wcnt - m0;
    checks++;
    if (nw !== N || nother !== 0)
      $display("FAIL %s write_count: %0d writes (%0d on other port), want %0d (0)",
               name, nw, nother, N);
    else passed++;
    ok = 1'b1;
    for (int k = 0; k < N && k < nw; k++) begin
      if (op == 2'd1) begin
        if (mem_wa[m0+k] !== ea_m[k] || mem_wd[m0+k] !== ed[k]) begin
          ok = 1'b0;
          $display("FAIL %s mem_write[%0d]: addr=%h data=%h, want addr=%h data=%h",
                   name, k, mem_wa[m0+k], mem_wd[m0+k], ea_m[k], ed[k]);
        end
        mem_store[mem_wa[m0+k]] = mem_wd[m0+k];
      end else begin
        if (hd_wa[h0+k] !== ea_h[k] || hd_wd[h0+k] !== ed[k]) begin
          ok = 1'b0;
          $display("FAIL %s hd_write[%0d]: addr=%h data=%h, want addr=%h data=%h",
                   name, k, hd_wa[h0+k], hd_wd[h0+k], ea_h[k], ed[k]);
        end
        hd_store[hd_wa[h0+k]] = hd_wd[h0+k];
      end
    end
    checks++;
    if (ok) passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b0 || hd_wr_en !== 1'b0 || mem_wr_en !== 1'b0 ||
        hd_addr !== '0 || mem_addr !== '0)
      $display("FAIL reset_state: pronto=%b ocupado=%b hwe=%b mwe=%b ha=%h ma=%h, want all 0",
               pronto, ocupado, hd_wr_en, mem_wr_en, hd_addr, mem_addr);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_read;
    for (int k = 0; k < N; k++) hd_store[{8'd3, 2'(k)}] = 32'hA0 + 32'(k);
    run_op(2'd1, 8'd3, 10'h010, 1'b0, "read");
    for (int k = 0; k < N; k++) begin
      checks++;
      if (mem_store[10'h010 + 10'(k)] !== 32'hA0 + 32'(k))
        $display("FAIL read_mem[%0d]: got %h, want %h", k, mem_store[10'h010 + 10'(k)],
                 32'hA0 + 32'(k));
      else passed++;
    end
  endtask

  task automatic test_write;
    for (int k = 0; k < N; k++) mem_store[10'h020 + 10'(k)] = 32'(k + 1);
    run_op(2'd2, 8'd5, 10'h020, 1'b0, "write");
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hd_store[{8'd5, 2'(k)}] !== 32'(k + 1))
        $display("FAIL write_hd[%0d]: got %h, want %h", k, hd_store[{8'd5, 2'(k)}], k + 1);
      else passed++;
    end
  endtask

  task automatic test_wrap;
    run_op(2'd1, 8'd7, 10'(MSIZE - 2), 1'b0, "wrap");
  endtask

  task automatic test_reset_mid;
    int m0;
    m0 = mem_wcnt;
    @(negedge clock);
    OpHD = 2'd1; setor = 8'd9; mem_base = 10'h100;
    @(posedge clock); #1;
    OpHD = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0 || mem_wr_en !== 1'b0)
      $display("FAIL reset_mid_state: ocupado=%b pronto=%b mwe=%b, want 0/0/0",
               ocupado, pronto, mem_wr_en);
    else passed++;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (mem_wcnt - m0 !== 2 || pronto !== 1'b0)
      $display("FAIL reset_mid_writes: %0d writes pronto=%b, want 2 and 0", mem_wcnt - m0, pronto);
    else passed++;
    run_op(2'd1, 8'd9, 10'h100, 1'b0, "after_reset");
  endtask

  task automatic test_done_hold;
    run_op(2'd1, 8'd11, 10'h200, 1'b1, "done_hold");
  endtask

  task automatic test_reserved;
    int h0, m0;
    bit ok;
    h0 = hd_wcnt;
    m0 = mem_wcnt;
    ok = 1'b1;
    @(negedge clock);
    OpHD = 2'd3;
    repeat (3) begin
      @(posedge clock); #1;
      if (ocupado !== 1'b0 || pronto !== 1'b0) ok = 1'b0;
    end
    @(negedge clock);
    OpHD = 2'd0;
    checks++;
    if (!ok || hd_wcnt !== h0 || mem_wcnt !== m0)
      $display("FAIL reserved: ok=%b hd_writes=%0d mem_writes=%0d, want idle and 0/0",
               ok, hd_wcnt - h0, mem_wcnt - m0);
    else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      run_op(2'($urandom_range(1, 2)), SW'($urandom), AW'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < HSIZE; i++) hd_store[i] = $urandom;
    for (int i = 0; i < MSIZE; i++) mem_store[i] = $urandom;
    reset = 1'b1; OpHD = 2'd0; setor = '0; mem_base = '0;
    test_reset;
    test_read;
    test_write;
    test_wrap;
    test_reset_mid;
    test_done_hold;
    test_reserved;
    test_random;
    checks++;
    if (both_err !== 0 || idle_err !== 0)
      $display("FAIL enable_rules: both_on=%0d idle_writes=%0d, want 0/0", both_err, idle_err);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
